// File: rtl/player_controller_pkg.sv
// Shared constants, enums and helpers for the PAC-MAN player controller.
// Contents: maze geometry, pixel/tile widths, heading codes, FSM states,
// and the row-major tile-index helper.
// Optional build macro PLAYER_TUNNEL_WRAP_EN is consumed by the modules, not here.
package player_controller_pkg;

  localparam int unsigned TILE_PX    = 16;
  localparam int unsigned STEP_PX    = 2;
  localparam int unsigned COLS       = 40;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned START_COL  = 20;
  localparam int unsigned START_ROW  = 22;

  localparam int unsigned TILE_SHIFT = $clog2(TILE_PX);
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned COL_W      = X_W - TILE_SHIFT;
  localparam int unsigned ROW_W      = Y_W - TILE_SHIFT;
  localparam int unsigned TILE_W     = 11;
  localparam int unsigned N_TILES    = ROWS * COLS;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHK_WANT,
    ST_CHK_CUR,
    ST_MOVE
  } state_e;

  // Row-major tile index: row*COLS + col
  function automatic logic [TILE_W-1:0] tile_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
    return TILE_W'(row) * TILE_W'(COLS) + TILE_W'(col);
  endfunction

endpackage

// File: rtl/player_controller_tile_wall_lookup.sv
// Registered wall lookup for the tile adjacent to (col,row) in direction dir.
// Ports: clk, reset (async, active-high), col, row, dir, walls (tilemap),
//        wall (registered: 1 if the neighbour is a wall or off the maze).
// Build macro PLAYER_TUNNEL_WRAP_EN: horizontal neighbours wrap around the
// maze instead of reading as wall past the left/right edge.
module player_controller_tile_wall_lookup
  import player_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COL_W-1:0]   col,
  input  logic [ROW_W-1:0]   row,
  input  logic [1:0]         dir,
  input  logic [N_TILES-1:0] walls,
  output logic               wall
);

  logic [COL_W-1:0]  nb_col;
  logic [ROW_W-1:0]  nb_row;
  logic              off_edge;
  logic [TILE_W-1:0] nb_idx;

  // Neighbour coordinates; anything outside the maze is a wall
  always_comb begin
    nb_col   = col;
    nb_row   = row;
    off_edge = 1'b0;
    case (dir)
      DIR_UP: begin
        if (row == ROW_W'(0)) off_edge = 1'b1;
        else                  nb_row   = row - ROW_W'(1);
      end
      DIR_DOWN: begin
        if (row == ROW_W'(ROWS-1)) off_edge = 1'b1;
        else                       nb_row   = row + ROW_W'(1);
      end
      DIR_LEFT: begin
        if (col == COL_W'(0)) begin
`ifdef PLAYER_TUNNEL_WRAP_EN
          nb_col = COL_W'(COLS-1);
`else
          off_edge = 1'b1;
`endif
        end else begin
          nb_col = col - COL_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (col == COL_W'(COLS-1)) begin
`ifdef PLAYER_TUNNEL_WRAP_EN
          nb_col = COL_W'(0);
`else
          off_edge = 1'b1;
`endif
        end else begin
          nb_col = col + COL_W'(1);
        end
      end
    endcase
    nb_idx = tile_index(nb_row, nb_col);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wall <= 1'b0;
    else       wall <= off_edge | walls[nb_idx];
  end

endmodule

// File: rtl/player_controller.sv
// PAC-MAN movement controller on the 40x30 tile maze.
// Ports: clk (25 MHz pixel clock), reset (async, active-high), step_en
//        (per-frame move pulse), w/a/s/d (raw key levels), walls (tilemap);
//        player_x/player_y (sprite top-left), dir (heading), moving,
//        eat_valid/eat_tile (newly entered tile, one-cycle pulse).
// Build macro PLAYER_TUNNEL_WRAP_EN: left/right tunnel wrap-around.
module player_controller
  import player_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               step_en,
  input  logic               w,
  input  logic               a,
  input  logic               s,
  input  logic               d,
  input  logic [N_TILES-1:0] walls,
  output logic [X_W-1:0]     player_x,
  output logic [Y_W-1:0]     player_y,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               eat_valid,
  output logic [TILE_W-1:0]  eat_tile
);

  state_e            state;
  logic [3:0]        key_s1, key_s2;
  logic [1:0]        want_dir;
  logic              want_free;
  logic              wall_bit;
  logic [1:0]        look_dir;
  logic              aligned;
  logic              do_step;
  logic [1:0]        step_dir;
  logic [X_W-1:0]    next_x;
  logic [Y_W-1:0]    next_y;
  logic              next_aligned;
  logic [TILE_W-1:0] next_tile;

  // Two-flop synchronizer for {w,a,s,d}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= {w, a, s, d};
      key_s2 <= key_s1;
    end
  end

  // Buffered turn request, priority w > a > s > d, held after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          want_dir <= DIR_LEFT;
    else if (key_s2[3]) want_dir <= DIR_UP;
    else if (key_s2[2]) want_dir <= DIR_LEFT;
    else if (key_s2[1]) want_dir <= DIR_DOWN;
    else if (key_s2[0]) want_dir <= DIR_RIGHT;
  end

  // One lookup shared: want_dir during CHK_WANT, dir during CHK_CUR
  assign look_dir = (state == ST_CHK_CUR) ? dir : want_dir;

  player_controller_tile_wall_lookup u_lookup (
    .clk   (clk),
    .reset (reset),
    .col   (player_x[X_W-1:TILE_SHIFT]),
    .row   (player_y[Y_W-1:TILE_SHIFT]),
    .dir   (look_dir),
    .walls (walls),
    .wall  (wall_bit)
  );

  assign aligned = (player_x[TILE_SHIFT-1:0] == '0) && (player_y[TILE_SHIFT-1:0] == '0);

  // Step decision and the resulting position
  always_comb begin
    do_step  = 1'b0;
    step_dir = dir;
    if (aligned) begin
      if (want_free) begin
        do_step  = 1'b1;
        step_dir = want_dir;
      end else if (!wall_bit) begin
        do_step  = 1'b1;
      end
    end else begin
      // Mid-tile: keep going; only an exact reversal may change heading
      do_step = 1'b1;
      if (want_dir == (dir ^ 2'b10)) step_dir = want_dir;
    end

    next_x = player_x;
    next_y = player_y;
    case (step_dir)
      DIR_UP:   next_y = player_y - Y_W'(STEP_PX);
      DIR_DOWN: next_y = player_y + Y_W'(STEP_PX);
      DIR_LEFT: begin
        next_x = player_x - X_W'(STEP_PX);
`ifdef PLAYER_TUNNEL_WRAP_EN
        if (player_x == '0) next_x = X_W'(COLS*TILE_PX - STEP_PX);
`endif
      end
      DIR_RIGHT: begin
        next_x = player_x + X_W'(STEP_PX);
`ifdef PLAYER_TUNNEL_WRAP_EN
        if (player_x >= X_W'(COLS*TILE_PX - STEP_PX)) next_x = '0;
`endif
      end
    endcase
    next_aligned = (next_x[TILE_SHIFT-1:0] == '0) && (next_y[TILE_SHIFT-1:0] == '0);
    next_tile    = tile_index(next_y[Y_W-1:TILE_SHIFT], next_x[X_W-1:TILE_SHIFT]);
  end

  // Step sequencer: IDLE -> CHK_WANT -> CHK_CUR -> MOVE -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      player_x  <= X_W'(START_COL*TILE_PX);
      player_y  <= Y_W'(START_ROW*TILE_PX);
      dir       <= DIR_LEFT;
      moving    <= 1'b0;
      eat_valid <= 1'b0;
      eat_tile  <= '0;
      want_free <= 1'b0;
    end else begin
      eat_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step_en) state <= ST_CHK_WANT;
        end
        ST_CHK_WANT: begin
          state <= ST_CHK_CUR;
        end
        ST_CHK_CUR: begin
          // Lookup now holds the want-direction result
          want_free <= ~wall_bit;
          state     <= ST_MOVE;
        end
        ST_MOVE: begin
          moving <= do_step;
          if (do_step) begin
            player_x  <= next_x;
            player_y  <= next_y;
            dir       <= step_dir;
            eat_valid <= next_aligned;
            if (next_aligned) eat_tile <= next_tile;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_controller.sv
// Directed self-checking bench for player_controller.
module tb_player_controller;

  logic         clk;
  logic         reset;
  logic         step_en;
  logic         w, a, s, d;
  logic [1199:0] walls;
  logic [9:0]   player_x;
  logic [8:0]   player_y;
  logic [1:0]   dir;
  logic         moving;
  logic         eat_valid;
  logic [10:0]  eat_tile;

  int vectors     = 0;
  int miscompares = 0;
  int eat_total   = 0;
  int eat_base;
  logic [10:0] last_eat = '0;

  player_controller dut (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .w         (w),
    .a         (a),
    .s         (s),
    .d         (d),
    .walls     (walls),
    .player_x  (player_x),
    .player_y  (player_y),
    .dir       (dir),
    .moving    (moving),
    .eat_valid (eat_valid),
    .eat_tile  (eat_tile)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Eat pulses observed away from the active edge
  always @(negedge clk) begin
    if (eat_valid) begin
      eat_total <= eat_total + 1;
      last_eat  <= eat_tile;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    step_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One movement pulse, then wait until the sequencer is back in IDLE
  task automatic do_step();
    @(negedge clk); step_en = 1'b1;
    @(negedge clk); step_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; step_en = 1'b0;
    w = 1'b0; a = 1'b0; s = 1'b0; d = 1'b0;
    walls = '0;

    // 1. Reset state, no eating while idle
    do_reset();
    check("rst_x", 32'(player_x), 32'd320);
    check("rst_y", 32'(player_y), 32'd352);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_eat_tile", 32'(eat_tile), 32'd0);
    eat_base = eat_total;
    repeat (100) @(negedge clk);
    check("idle_no_eat", 32'(eat_total - eat_base), 32'd0);

    // 2. Hold d in empty maze; latency and ignored overlapping step_en
    d = 1'b1;
    repeat (4) @(negedge clk);
    eat_base = eat_total;
    @(negedge clk); step_en = 1'b1;
    @(negedge clk); step_en = 1'b0;
    @(negedge clk); step_en = 1'b1;   // arrives mid-sequence, must be dropped
    @(negedge clk); step_en = 1'b0;
    check("lat_x_before", 32'(player_x), 32'd320);
    @(negedge clk);
    check("lat_x_after", 32'(player_x), 32'd322);
    @(negedge clk);
    check("overlap_ignored_x", 32'(player_x), 32'd322);
    repeat (7) do_step();
    check("right_dir", 32'(dir), 32'd3);
    check("right_x", 32'(player_x), 32'd336);
    check("right_moving", 32'(moving), 32'd1);
    check("right_eat_count", 32'(eat_total - eat_base), 32'd1);
    check("right_eat_tile", 32'(last_eat), 32'd901);
    d = 1'b0;

    // 3. Wall right of start: wanted turn blocked, keep going left
    walls = '0;
    walls[22*40+21] = 1'b1;
    d = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    do_step();
    check("blk_x", 32'(player_x), 32'd318);
    check("blk_dir", 32'(dir), 32'd1);
    d = 1'b0;

    // 4. Mid-tile reversal at x=316
    walls = '0;
    do_reset();
    do_step();
    do_step();
    check("rev_pre_x", 32'(player_x), 32'd316);
    d = 1'b1;
    repeat (4) @(negedge clk);
    do_step();
    check("rev_dir", 32'(dir), 32'd3);
    check("rev_x", 32'(player_x), 32'd318);
    d = 1'b0;

    // 5. Buffered turn: tap w mid-tile, turn at next alignment
    do_reset();
    repeat (3) do_step();
    check("buf_pre_x", 32'(player_x), 32'd314);
    w = 1'b1;
    repeat (3) @(negedge clk);
    w = 1'b0;
    repeat (3) @(negedge clk);
    do_step();
    check("buf_mid_dir", 32'(dir), 32'd1);
    eat_base = eat_total;
    repeat (4) do_step();
    check("buf_align_x", 32'(player_x), 32'd304);
    check("buf_align_dir", 32'(dir), 32'd1);
    check("buf_eat_tile", 32'(last_eat), 32'd899);
    check("buf_eat_count", 32'(eat_total - eat_base), 32'd1);
    do_step();
    check("buf_turn_dir", 32'(dir), 32'd0);
    check("buf_turn_y", 32'(player_y), 32'd350);
    check("buf_turn_x", 32'(player_x), 32'd304);

    // 6. Left edge of the maze: wrap or stop depending on build
    a = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    repeat (160) do_step();
    check("edge_x", 32'(player_x), 32'd0);
    check("edge_eat_tile", 32'(last_eat), 32'd880);
    eat_base = eat_total;
    do_step();
`ifdef PLAYER_TUNNEL_WRAP_EN
    check("wrap_x", 32'(player_x), 32'd638);
    check("wrap_moving", 32'(moving), 32'd1);
`else
    check("stop_x", 32'(player_x), 32'd0);
    check("stop_moving", 32'(moving), 32'd0);
`endif
    check("edge_dir", 32'(dir), 32'd1);
    check("edge_no_eat", 32'(eat_total - eat_base), 32'd0);
    a = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
